// File: rtl/real_div.sv
// real_div: sequential IEEE-754 divider (binary32 or binary64), restoring
// mantissa divide at one quotient bit per clock, fixed latency of N+2 cycles.
module real_div #(
  parameter bit          IS_DOUBLE  = 1'b0,
  parameter int unsigned EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
  parameter int unsigned MANT_WIDTH = IS_DOUBLE ? 52 : 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   b,
  output logic                            busy,
  output logic                            done,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   result,
  output logic                            flag_dz,
  output logic                            flag_ovf,
  output logic                            flag_unf,
  output logic                            flag_inv
);

  localparam int unsigned W    = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int unsigned N    = MANT_WIDTH + 3;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int unsigned EW   = EXP_WIDTH + 2;
  localparam int unsigned BIAS = IS_DOUBLE ? 1023 : 127;
  localparam int unsigned MW   = MANT_WIDTH + 1;
  localparam int unsigned RW   = MANT_WIDTH + 2;

  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_RND,
    S_FIN
  } state_t;

  typedef enum logic [2:0] {
    SP_NONE,
    SP_NAN,
    SP_DZ,
    SP_INF,
    SP_ZERO
  } spec_t;

  state_t state_q, state_nxt;

  // control strobes decoded from the FSM
  logic do_load, do_step, do_round, do_publish;

  // captured operation context
  logic                 sign_q;
  spec_t                spec_q;
  logic signed [EW-1:0] exp_q;
  logic [MW-1:0]        mb_q;
  logic [RW-1:0]        rem_q;
  logic [N-1:0]         quo_q;
  logic [CW-1:0]        cnt_q;

  // rounded result staged between RND and the done edge
  logic [W-1:0]         pend_result_q;
  logic [3:0]           pend_flags_q;

  // operand fields and classification
  logic [EXP_WIDTH-1:0]  ea, eb;
  logic [MANT_WIDTH-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic a_max, b_max;
  spec_t spec_in;
  logic signed [EW-1:0] exp_init;

  assign ea = a[W-2 -: EXP_WIDTH];
  assign eb = b[W-2 -: EXP_WIDTH];
  assign fa = a[MANT_WIDTH-1:0];
  assign fb = b[MANT_WIDTH-1:0];

  assign a_max  = &ea;
  assign b_max  = &eb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = a_max && (fa == '0);
  assign b_inf  = b_max && (fb == '0);
  assign a_nan  = a_max && (fa != '0);
  assign b_nan  = b_max && (fb != '0);

  assign exp_init = EW'(ea) - EW'(eb) + EW'(BIAS);

  // special-case classification in priority order
  always_comb begin
    spec_in = SP_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_in = SP_NAN;
    end else if (b_zero && !a_zero && !a_inf) begin
      spec_in = SP_DZ;
    end else if (a_inf) begin
      spec_in = SP_INF;
    end else if (a_zero || b_inf) begin
      spec_in = SP_ZERO;
    end
  end

  // one restoring step: compare, conditionally subtract, shift
  logic          rem_ge;
  logic [RW-1:0] rem_sub, rem_nxt;
  logic [N-1:0]  quo_nxt;

  always_comb begin
    rem_ge  = (rem_q >= {1'b0, mb_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_nxt = rem_sub << 1;
    quo_nxt = {quo_q[N-2:0], rem_ge};
  end

  // normalise, round half-up on the guard bit, range check, special override
  // Quotient MSB carries weight 2^0, so quo_q[N-1] set means ma/mb >= 1.
  logic                  q_hi, guard;
  logic [MANT_WIDTH-1:0] frac_raw, frac_rnd;
  logic [MANT_WIDTH:0]   frac_sum;
  logic signed [EW-1:0]  e_norm, e_rnd;
  logic                  ovf, unf;
  logic [W-1:0]          rnd_result;
  logic [3:0]            rnd_flags;

  always_comb begin
    q_hi       = quo_q[N-1];
    frac_raw   = q_hi ? quo_q[MANT_WIDTH+1:2] : quo_q[MANT_WIDTH:1];
    guard      = q_hi ? quo_q[1] : quo_q[0];
    e_norm     = q_hi ? exp_q : (exp_q - EW'(1));
    frac_sum   = {1'b0, frac_raw} + {{MANT_WIDTH{1'b0}}, guard};
    frac_rnd   = frac_sum[MANT_WIDTH-1:0];
    e_rnd      = e_norm + EW'(frac_sum[MANT_WIDTH]);
    ovf        = !e_rnd[EW-1] && (e_rnd >= EXP_MAX);
    unf        = e_rnd[EW-1] || (e_rnd == '0);
    rnd_result = '0;
    rnd_flags  = 4'b0000;
    case (spec_q)
      SP_NAN: begin
        rnd_result = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
        rnd_flags  = 4'b1000;
      end
      SP_DZ: begin
        rnd_result = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        rnd_flags  = 4'b0100;
      end
      SP_INF: begin
        rnd_result = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      end
      SP_ZERO: begin
        rnd_result = {sign_q, {(W-1){1'b0}}};
      end
      default: begin
        if (ovf) begin
          rnd_result = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          rnd_flags  = 4'b0010;
        end else if (unf) begin
          rnd_result = {sign_q, {(W-1){1'b0}}};
          rnd_flags  = 4'b0001;
        end else begin
          rnd_result = {sign_q, e_rnd[EXP_WIDTH-1:0], frac_rnd};
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next-state and control strobes
  always_comb begin
    state_nxt  = state_q;
    do_load    = 1'b0;
    do_step    = 1'b0;
    do_round   = 1'b0;
    do_publish = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          do_load   = 1'b1;
          state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        do_step = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_nxt = S_RND;
        end
      end
      S_RND: begin
        do_round  = 1'b1;
        state_nxt = S_FIN;
      end
      S_FIN: begin
        do_publish = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q        <= 1'b0;
      spec_q        <= SP_NONE;
      exp_q         <= '0;
      mb_q          <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      pend_result_q <= '0;
      pend_flags_q  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      flag_inv      <= 1'b0;
      flag_dz       <= 1'b0;
      flag_ovf      <= 1'b0;
      flag_unf      <= 1'b0;
    end else begin
      done <= do_publish;
      if (do_load) begin
        sign_q <= a[W-1] ^ b[W-1];
        spec_q <= spec_in;
        exp_q  <= exp_init;
        mb_q   <= {1'b1, fb};
        rem_q  <= {1'b0, 1'b1, fa};
        quo_q  <= '0;
        cnt_q  <= CW'(N);
        busy   <= 1'b1;
      end
      if (do_step) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CW'(1);
      end
      if (do_round) begin
        pend_result_q <= rnd_result;
        pend_flags_q  <= rnd_flags;
      end
      if (do_publish) begin
        busy     <= 1'b0;
        result   <= pend_result_q;
        flag_inv <= pend_flags_q[3];
        flag_dz  <= pend_flags_q[2];
        flag_ovf <= pend_flags_q[1];
        flag_unf <= pend_flags_q[0];
      end
    end
  end

endmodule
